// File: rtl/pipeline_pkg.sv
// Shared fetch-path types and constants.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // One prefetch buffer slot: fetch PC, returned instruction, instruction present
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order prefetch ring: entries are allocated at request accept, filled by
// in-order responses and popped into the IF/ID register. Pointers carry one
// extra wrap bit so full and empty are distinguishable.
module fetch_buffer
   import pipeline_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    alloc_en,
   input  logic [XLEN-1:0]         alloc_pc,
   input  logic                    fill_en,
   input  logic [XLEN-1:0]         fill_instr,
   input  logic                    pop_en,
   output logic                    full,
   output logic                    head_filled,
   output logic [XLEN-1:0]         head_pc,
   output logic [XLEN-1:0]         head_instr,
   output logic [$clog2(DEPTH):0]  outstanding
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   fetch_entry_t  ring_q [DEPTH];
   logic [PW-1:0] alloc_q;
   logic [PW-1:0] fill_q;
   logic [PW-1:0] head_q;
   logic [AW-1:0] alloc_idx;
   logic [AW-1:0] fill_idx;
   logic [AW-1:0] head_idx;

   assign alloc_idx   = alloc_q[AW-1:0];
   assign fill_idx    = fill_q[AW-1:0];
   assign head_idx    = head_q[AW-1:0];
   assign full        = (alloc_q - head_q) == PW'(DEPTH);
   assign outstanding = alloc_q - fill_q;
   assign head_filled = ring_q[head_idx].filled && (alloc_q != head_q);
   assign head_pc     = ring_q[head_idx].pc;
   assign head_instr  = ring_q[head_idx].instr;

   // Pointer and slot updates; clear drops every entry in one cycle
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         alloc_q <= '0;
         fill_q  <= '0;
         head_q  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ring_q[AW'(i)].filled <= 1'b0;
         end
      end else begin
         if (alloc_en) begin
            ring_q[alloc_idx].pc     <= alloc_pc;
            ring_q[alloc_idx].filled <= 1'b0;
            alloc_q                  <= alloc_q + PW'(1);
         end
         if (fill_en) begin
            ring_q[fill_idx].instr  <= fill_instr;
            ring_q[fill_idx].filled <= 1'b1;
            fill_q                  <= fill_q + PW'(1);
         end
         if (pop_en) begin
            head_q <= head_q + PW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: sequential PC requests to a variable-latency
// memory, in-order prefetch buffer, stale-response drop on redirect, and the
// IF/ID register feeding decode.
module fetch_prefetch_unit
   import pipeline_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   input  logic            StallD,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic [XLEN-1:0] InstrD,
   output logic [XLEN-1:0] PCD,
   output logic [XLEN-1:0] PCPlus4D,
   output logic            ValidD
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] pc_q;
   logic [PW-1:0]   drop_q;
   logic [PW-1:0]   drop_d;
   logic            full;
   logic            head_filled;
   logic [XLEN-1:0] head_pc;
   logic [XLEN-1:0] head_instr;
   logic [PW-1:0]   outstanding;
   logic            req_fire_c;
   logic            rsp_keep_c;
   logic            rsp_drop_c;
   logic            rsp_counted_c;
   logic            pop_c;

   // Request is combinational so it can be withdrawn on redirect/reset only
   assign imem_req_valid = !rst && !PCSrcE && !full;
   assign imem_req_addr  = pc_q;
   assign req_fire_c     = imem_req_valid && imem_req_ready;

   assign rsp_drop_c    = imem_rsp_valid && (drop_q != '0);
   assign rsp_keep_c    = imem_rsp_valid && (drop_q == '0) && (outstanding != '0) && !PCSrcE;
   assign rsp_counted_c = imem_rsp_valid && ((drop_q != '0) || (outstanding != '0));
   assign pop_c         = !PCSrcE && !StallD && head_filled;

   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk         (clk),
      .rst         (rst),
      .clear       (PCSrcE),
      .alloc_en    (req_fire_c),
      .alloc_pc    (pc_q),
      .fill_en     (rsp_keep_c),
      .fill_instr  (imem_rsp_data),
      .pop_en      (pop_c),
      .full        (full),
      .head_filled (head_filled),
      .head_pc     (head_pc),
      .head_instr  (head_instr),
      .outstanding (outstanding)
   );

   // Responses still owed by memory for squashed requests; a response arriving
   // in the redirect cycle itself is already accounted for
   always_comb begin
      drop_d = drop_q;
      if (PCSrcE) begin
         drop_d = drop_q + outstanding - PW'(rsp_counted_c);
      end else if (rsp_drop_c) begin
         drop_d = drop_q - PW'(1);
      end
   end

   // Fetch PC and drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
         if (PCSrcE) begin
            pc_q <= PCTargetE;
         end else if (req_fire_c) begin
            pc_q <= pc_q + XLEN'(4);
         end
      end
   end

   // IF/ID register: redirect bubbles, stall holds, else pop or bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         InstrD   <= NOP_INSTR;
         PCD      <= '0;
         PCPlus4D <= '0;
         ValidD   <= 1'b0;
      end else if (PCSrcE) begin
         InstrD <= NOP_INSTR;
         ValidD <= 1'b0;
      end else if (!StallD) begin
         if (head_filled) begin
            InstrD   <= head_instr;
            PCD      <= head_pc;
            PCPlus4D <= head_pc + XLEN'(4);
            ValidD   <= 1'b1;
         end else begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end
      end
   end

   // Squashed responses never exceed the buffer depth
   a_drop_bound : assert property (@(posedge clk) disable iff (rst)
      drop_q <= PW'(DEPTH));

   // Every response must belong to an outstanding or squashed request
   a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> ((drop_q != '0) || (outstanding != '0)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit with an in-order memory model and a
// queue-based reference of the prefetch/IF-ID behaviour.
module tb_fetch_prefetch_unit;
   import pipeline_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        StallD;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;
   logic        ValidD;

   fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .PCSrcE         (PCSrcE),
      .PCTargetE      (PCTargetE),
      .StallD         (StallD),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .InstrD         (InstrD),
      .PCD            (PCD),
      .PCPlus4D       (PCPlus4D),
      .ValidD         (ValidD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      int          rc;
   } bent_t;

   mreq_t       mq[$];
   bent_t       bq[$];
   int          n_checks;
   int          n_fail;
   int          cyc;
   int          last_due;
   logic [31:0] mpc;
   logic [31:0] e_instr;
   logic [31:0] e_pcd;
   logic [31:0] e_pc4;
   logic        e_valid;
   bit          redirected;

   bit          k_rst;
   bit          k_stall;
   bit          k_pcsrc;
   bit          k_redirect_on_rsp;
   logic [31:0] k_target;
   int          k_ready_pct;
   int          k_lat_min;
   int          k_lat_max;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a >> 2;
   endfunction

   function automatic bit has_stale();
      foreach (mq[i]) if (mq[i].stale) return 1'b1;
      return 1'b0;
   endfunction

   // One clock: drive at negedge, check request side, then check IF/ID after posedge
   task automatic step();
      mreq_t r;
      bit    rsp;
      bit    hs;
      bit    exp_rv;
      int    due;
      @(negedge clk);
      rsp = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         r   = mq.pop_front();
         rsp = 1'b1;
      end
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? instr_of(r.addr) : $urandom();
      rst            = k_rst;
      StallD         = k_stall;
      PCSrcE         = k_pcsrc || (k_redirect_on_rsp && rsp);
      PCTargetE      = k_target;
      imem_req_ready = ($urandom_range(0, 99) < k_ready_pct);
      redirected     = !rst && PCSrcE;
      #1;
      exp_rv = !rst && !PCSrcE && (bq.size() < DEPTH);
      check_val("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) check_val("req_addr", imem_req_addr, mpc);
      hs = exp_rv && imem_req_ready;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         bq.delete();
         mpc      = RESET_PC;
         e_instr  = NOP_INSTR;
         e_pcd    = '0;
         e_pc4    = '0;
         e_valid  = 1'b0;
         last_due = cyc;
      end else if (PCSrcE) begin
         foreach (mq[i]) mq[i].stale = 1'b1;
         bq.delete();
         mpc     = PCTargetE;
         e_instr = NOP_INSTR;
         e_valid = 1'b0;
      end else begin
         if (!StallD) begin
            if (bq.size() > 0 && bq[0].rc >= 0) begin
               e_pcd   = bq[0].pc;
               e_pc4   = e_pcd + 32'd4;
               e_instr = instr_of(e_pcd);
               e_valid = 1'b1;
               void'(bq.pop_front());
            end else begin
               e_instr = NOP_INSTR;
               e_valid = 1'b0;
            end
         end
         if (rsp && !r.stale) begin
            for (int i = 0; i < bq.size(); i++) begin
               if (bq[i].rc < 0) begin
                  bq[i].rc = cyc;
                  break;
               end
            end
         end
         if (hs) begin
            bq.push_back('{pc: mpc, rc: -1});
            due = cyc + $urandom_range(k_lat_min, k_lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr: mpc, due: due, stale: 1'b0});
            mpc = mpc + 32'd4;
         end
      end
      check_val("ValidD", 32'(ValidD), 32'(e_valid));
      check_val("InstrD", InstrD, e_instr);
      check_val("PCD", PCD, e_pcd);
      check_val("PCPlus4D", PCPlus4D, e_pc4);
      cyc++;
   endtask

   initial begin
      int first_valid;
      int nvalid;
      int guard;
      bit seen;

      n_checks = 0; n_fail = 0; cyc = 0; last_due = 0;
      mpc = RESET_PC; e_instr = NOP_INSTR; e_pcd = '0; e_pc4 = '0; e_valid = 1'b0;
      rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallD = 1'b0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      k_rst = 1'b1; k_stall = 1'b0; k_pcsrc = 1'b0; k_redirect_on_rsp = 1'b0;
      k_target = '0; k_ready_pct = 100; k_lat_min = 1; k_lat_max = 1;

      repeat (3) step();

      // Latency 1, always ready: first valid in cycle 3, then one per cycle
      k_rst = 1'b0;
      first_valid = -1; nvalid = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ValidD) begin
            nvalid++;
            if (first_valid < 0) first_valid = i + 1;
         end
      end
      check_val("first_valid_cycle", 32'(first_valid), 32'd3);
      check_val("stream_valid_count", 32'(nvalid), 32'd18);

      // Latency 3: buffer depth limits outstanding requests
      k_lat_min = 3; k_lat_max = 3;
      repeat (20) step();

      // Stall five cycles: IF/ID holds, buffer fills, requests stop
      k_lat_min = 1; k_lat_max = 1;
      k_stall = 1'b1;
      repeat (5) step();
      check_val("stall_full_req_valid", 32'(imem_req_valid), 32'd0);
      k_stall = 1'b0;
      repeat (10) step();

      // Redirect to 0x100 with three requests in flight
      k_lat_min = 4; k_lat_max = 4;
      guard = 0;
      while (!(mq.size() == 3 && !has_stale()) && guard < 50) begin
         step();
         guard++;
      end
      check_val("reach_3_outstanding", 32'(guard < 50), 32'd1);
      k_pcsrc = 1'b1; k_target = 32'h0000_0100;
      step();
      k_pcsrc = 1'b0;
      check_val("redirect_bubble_valid", 32'(ValidD), 32'd0);
      check_val("redirect_bubble_instr", InstrD, NOP_INSTR);
      check_val("redirect_drop_cnt", 32'(dut.drop_q), 32'(mq.size()));
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (ValidD && !seen) begin
            seen = 1'b1;
            check_val("first_pc_after_redirect", PCD, 32'h0000_0100);
         end
      end
      check_val("redirect_stream_resumed", 32'(seen), 32'd1);

      // Redirect coincident with a live response while stalled
      k_lat_min = 2; k_lat_max = 3;
      guard = 0;
      while (!(mq.size() > 0 && mq[0].due == cyc && !has_stale()) && guard < 60) begin
         step();
         guard++;
      end
      k_stall = 1'b1; k_redirect_on_rsp = 1'b1; k_target = 32'h0000_0200;
      step();
      k_stall = 1'b0; k_redirect_on_rsp = 1'b0;
      check_val("coincident_redirect_taken", 32'(redirected), 32'd1);
      check_val("coincident_bubble_valid", 32'(ValidD), 32'd0);
      check_val("coincident_drop_cnt", 32'(dut.drop_q), 32'(mq.size()));
      repeat (25) step();

      // Reset mid-stream with responses pending
      k_lat_min = 3; k_lat_max = 3;
      repeat (6) step();
      k_rst = 1'b1;
      step();
      check_val("midrst_ValidD", 32'(ValidD), 32'd0);
      check_val("midrst_InstrD", InstrD, NOP_INSTR);
      check_val("midrst_PCD", PCD, 32'd0);
      k_rst = 1'b0;
      repeat (15) step();

      // Randomized traffic: ready, latency, stalls, redirects, rare resets
      k_ready_pct = 70; k_lat_min = 1; k_lat_max = 4;
      for (int i = 0; i < 800; i++) begin
         k_stall  = ($urandom_range(0, 99) < 20);
         k_rst    = ($urandom_range(0, 199) == 0);
         k_pcsrc  = ($urandom_range(0, 99) < 4) && !has_stale();
         k_target = 32'h0000_1000 + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
         step();
      end

      // Drain
      k_stall = 1'b0; k_rst = 1'b0; k_pcsrc = 1'b0; k_ready_pct = 100;
      repeat (30) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
